// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired multi-cycle control sequencer for a 32-bit load/store CPU
//
// Purpose:
//   Steps through fetch (T0-T2) and execute (T3-T7) phases, decoding the
//   instruction class from IR[31:27], and drives the datapath strobes for
//   each step. Strobes depend only on the current step and the class of the
//   instruction held in IR.
//
// Ports:
//   Clock            - system clock, rising edge active
//   Clear            - asynchronous active-low reset
//   IR[31:0]         - instruction register, opcode = IR[31:27]
//   Stop             - halt request, sampled only on the last step of an instruction
//   PCout..RAM_write - memory / register-file strobes
//   Gra..ZLowout     - datapath strobes
//   ALU_op[4:0]      - ALU operation select, combinational from IR
//   Run              - 1 while executing, 0 in HALT
//   State[3:0]       - current step, for debug

module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        MAR_enable,
  output logic        IncPC,
  output logic        PC_enable,
  output logic        MDR_read,
  output logic        MDR_enable,
  output logic        MDRout,
  output logic        IR_enable,
  output logic        RAM_write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic        BAout,
  output logic        Cout,
  output logic        Y_enable,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowout,
  output logic [4:0]  ALU_op,
  output logic        Run,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b01001;
  localparam logic [4:0] ALU_OR  = 5'b01010;

  state_t state_q, state_d;

  logic [4:0] opcode;
  logic       is_r, is_imm, is_ldi, is_ld, is_st, is_mem, is_halt;
  logic       is_exec;

  assign opcode  = IR[31:27];
  // R-type occupies the contiguous opcode range add..or.
  assign is_r    = (opcode >= OP_ADD) && (opcode <= OP_OR);
  assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_mem  = is_ld || is_st;
  assign is_halt = (opcode == OP_HALT);
  // Any class that has an execute phase; everything else (nop, undefined)
  // finishes at T2.
  assign is_exec = is_r || is_imm || is_ldi || is_mem;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (is_exec) begin
          state_d = S_T3;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          // nop / undefined: T2 is the last step, so Stop is honoured here.
          state_d = Stop ? S_HALT : S_T0;
        end
      end
      S_T3:   state_d = S_T4;
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (is_mem) begin
          state_d = S_T6;
        end else begin
          state_d = Stop ? S_HALT : S_T0;
        end
      end
      S_T6:   state_d = S_T7;
      S_T7:   state_d = Stop ? S_HALT : S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Strobe decode (Moore: current step plus instruction class)
  // ---------------------------------------------------------------------
  always_comb begin
    PCout      = 1'b0;
    MAR_enable = 1'b0;
    IncPC      = 1'b0;
    PC_enable  = 1'b0;
    MDR_read   = 1'b0;
    MDR_enable = 1'b0;
    MDRout     = 1'b0;
    IR_enable  = 1'b0;
    RAM_write  = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    R_in       = 1'b0;
    R_out      = 1'b0;
    BAout      = 1'b0;
    Cout       = 1'b0;
    Y_enable   = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    ZLowout    = 1'b0;

    case (state_q)
      S_T0: begin
        // PC onto the bus into MAR; the incremented PC is captured in Z.
        PCout      = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        ZLowIn     = 1'b1;
      end
      S_T1: begin
        ZLowout    = 1'b1;
        PC_enable  = 1'b1;
        MDR_read   = 1'b1;
        MDR_enable = 1'b1;
      end
      S_T2: begin
        MDRout     = 1'b1;
        IR_enable  = 1'b1;
      end
      S_T3: begin
        if (is_ldi || is_mem) begin
          // Base register read through BAout so r0 reads as zero.
          Grb      = 1'b1;
          BAout    = 1'b1;
          Y_enable = 1'b1;
        end else if (is_r || is_imm) begin
          Grb      = 1'b1;
          R_out    = 1'b1;
          Y_enable = 1'b1;
        end
      end
      S_T4: begin
        if (is_r) begin
          Grc     = 1'b1;
          R_out   = 1'b1;
          ZLowIn  = 1'b1;
          ZHighIn = 1'b1;
        end else if (is_imm) begin
          Cout    = 1'b1;
          ZLowIn  = 1'b1;
          ZHighIn = 1'b1;
        end else if (is_ldi || is_mem) begin
          Cout    = 1'b1;
          ZLowIn  = 1'b1;
        end
      end
      S_T5: begin
        if (is_mem) begin
          // Effective address from Z into MAR.
          ZLowout    = 1'b1;
          MAR_enable = 1'b1;
        end else if (is_r || is_imm || is_ldi) begin
          ZLowout    = 1'b1;
          Gra        = 1'b1;
          R_in       = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          MDR_read   = 1'b1;
          MDR_enable = 1'b1;
        end else if (is_st) begin
          // MDR loads from the bus, not memory, for a store.
          Gra        = 1'b1;
          R_out      = 1'b1;
          MDR_enable = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout    = 1'b1;
          Gra       = 1'b1;
          R_in      = 1'b1;
        end else if (is_st) begin
          RAM_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // ALU operation select, straight from IR
  // ---------------------------------------------------------------------
  always_comb begin
    ALU_op = 5'b00000;
    if (is_r) begin
      ALU_op = opcode;
    end else if ((opcode == OP_ADDI) || is_ld || is_ldi || is_st) begin
      ALU_op = ALU_ADD;
    end else if (opcode == OP_ANDI) begin
      ALU_op = ALU_AND;
    end else if (opcode == OP_ORI) begin
      ALU_op = ALU_OR;
    end
  end

  assign Run   = (state_q != S_HALT);
  assign State = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard testbench for control_unit

module tb_control_unit;

  logic        Clock;
  logic        Clear;
  logic [31:0] IR;
  logic        Stop;
  logic        PCout, MAR_enable, IncPC, PC_enable, MDR_read, MDR_enable, MDRout;
  logic        IR_enable, RAM_write, Gra, Grb, Grc, R_in, R_out, BAout, Cout;
  logic        Y_enable, ZLowIn, ZHighIn, ZLowout;
  logic [4:0]  ALU_op;
  logic        Run;
  logic [3:0]  State;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
    .PCout(PCout), .MAR_enable(MAR_enable), .IncPC(IncPC), .PC_enable(PC_enable),
    .MDR_read(MDR_read), .MDR_enable(MDR_enable), .MDRout(MDRout),
    .IR_enable(IR_enable), .RAM_write(RAM_write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .BAout(BAout),
    .Cout(Cout), .Y_enable(Y_enable), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowout(ZLowout), .ALU_op(ALU_op), .Run(Run), .State(State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [19:0] B_PCOUT = 20'd1 << 19;
  localparam logic [19:0] B_MARE  = 20'd1 << 18;
  localparam logic [19:0] B_INCPC = 20'd1 << 17;
  localparam logic [19:0] B_PCE   = 20'd1 << 16;
  localparam logic [19:0] B_MDRR  = 20'd1 << 15;
  localparam logic [19:0] B_MDRE  = 20'd1 << 14;
  localparam logic [19:0] B_MDRO  = 20'd1 << 13;
  localparam logic [19:0] B_IRE   = 20'd1 << 12;
  localparam logic [19:0] B_RAMW  = 20'd1 << 11;
  localparam logic [19:0] B_GRA   = 20'd1 << 10;
  localparam logic [19:0] B_GRB   = 20'd1 << 9;
  localparam logic [19:0] B_GRC   = 20'd1 << 8;
  localparam logic [19:0] B_RIN   = 20'd1 << 7;
  localparam logic [19:0] B_ROUT  = 20'd1 << 6;
  localparam logic [19:0] B_BAOUT = 20'd1 << 5;
  localparam logic [19:0] B_COUT  = 20'd1 << 4;
  localparam logic [19:0] B_YE    = 20'd1 << 3;
  localparam logic [19:0] B_ZLI   = 20'd1 << 2;
  localparam logic [19:0] B_ZHI   = 20'd1 << 1;
  localparam logic [19:0] B_ZLO   = 20'd1 << 0;

  localparam int K_R = 0, K_IMM = 1, K_LDI = 2, K_LD = 3, K_ST = 4, K_NOP = 5, K_HLT = 6;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_HALT = 4'd9;

  logic [19:0] got_sb;
  assign got_sb = {PCout, MAR_enable, IncPC, PC_enable, MDR_read, MDR_enable, MDRout,
                   IR_enable, RAM_write, Gra, Grb, Grc, R_in, R_out, BAout, Cout,
                   Y_enable, ZLowIn, ZHighIn, ZLowout};

  typedef struct {
    logic [3:0]  st;
    logic [19:0] sb;
    logic        run;
    logic [4:0]  alu;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   tag_n = 0;
  logic [4:0] cur_alu;
  logic finish_req = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Hand-written step table: strobes expected for each step of each class.
  function automatic logic [19:0] exp_sb(input int kind, input int step);
    logic [19:0] v;
    v = '0;
    case (step)
      0: v = B_PCOUT | B_MARE | B_INCPC | B_ZLI;
      1: v = B_ZLO | B_PCE | B_MDRR | B_MDRE;
      2: v = B_MDRO | B_IRE;
      3: v = (kind == K_R || kind == K_IMM) ? (B_GRB | B_ROUT | B_YE) : (B_GRB | B_BAOUT | B_YE);
      4: v = (kind == K_R)   ? (B_GRC | B_ROUT | B_ZLI | B_ZHI) :
             (kind == K_IMM) ? (B_COUT | B_ZLI | B_ZHI) : (B_COUT | B_ZLI);
      5: v = (kind == K_LD || kind == K_ST) ? (B_ZLO | B_MARE) : (B_ZLO | B_GRA | B_RIN);
      6: v = (kind == K_LD) ? (B_MDRR | B_MDRE) : (B_GRA | B_ROUT | B_MDRE);
      7: v = (kind == K_LD) ? (B_MDRO | B_GRA | B_RIN) : B_RAMW;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [3:0] st, input logic [19:0] sb, input logic run);
    exp_t e;
    e.st = st; e.sb = sb; e.run = run; e.alu = cur_alu; e.tag = tag_n;
    tag_n++;
    exp_q.push_back(e);
  endtask

  // Clear held low for nlow cycles, then released for one IDLE cycle.
  task automatic do_reset(input int nlow);
    for (int i = 0; i < nlow; i++) begin
      tick(); Clear = 1'b0; Stop = 1'b0; push(ST_IDLE, '0, 1'b1);
    end
    tick(); Clear = 1'b1; push(ST_IDLE, '0, 1'b1);
  endtask

  task automatic halt_wait(input int n);
    for (int i = 0; i < n; i++) begin
      tick(); Stop = 1'b0; push(ST_HALT, '0, 1'b0);
    end
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic [4:0] alu, input int kind,
                           input logic [7:0] stop_mask, input int abort_step);
    int n;
    n = (kind == K_LD || kind == K_ST) ? 8 : (kind == K_NOP || kind == K_HLT) ? 3 : 6;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) begin IR = ir; cur_alu = alu; end
      Stop = stop_mask[i];
      if (i == abort_step) begin
        Clear = 1'b0; Stop = 1'b0;
        push(ST_IDLE, '0, 1'b1);
        return;
      end
      push(4'(i + 1), exp_sb(kind, i), 1'b1);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (finish_req) break;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (State !== e.st || got_sb !== e.sb || Run !== e.run || ALU_op !== e.alu) begin
          bad++;
          $display("FAIL step%0d: got state=%0d strobes=%05h run=%0b alu=%05b, want state=%0d strobes=%05h run=%0b alu=%05b",
                   e.tag, State, got_sb, Run, ALU_op, e.st, e.sb, e.run, e.alu);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    Clear = 1'b0; Stop = 1'b0; IR = 32'h0; cur_alu = 5'b00011;
    do_reset(2);
    run_instr(32'h69080002, 5'b01010, K_IMM, 8'h00, -1); // ori r2,r1,2
    run_instr(32'h1A920000, 5'b00011, K_R,   8'h00, -1); // add r5,r2,r4
    run_instr(32'h00800055, 5'b00011, K_LD,  8'h00, -1); // ld r1,0x55(r0)
    run_instr(32'h12080090, 5'b00011, K_ST,  8'h00, -1); // st 0x90(r1),r4
    run_instr(32'h08800005, 5'b00011, K_LDI, 8'h00, -1); // ldi
    run_instr(32'h60000000, 5'b01001, K_IMM, 8'h00, -1); // andi
    run_instr(32'h28000000, 5'b00101, K_R,   8'h00, -1); // shr
    run_instr(32'hC8000000, 5'b00000, K_NOP, 8'h00, -1); // nop
    run_instr(32'hF8000000, 5'b00000, K_NOP, 8'h00, -1); // undefined opcode
    run_instr(32'h69080002, 5'b01010, K_IMM, 8'h08, -1); // Stop only in T3: ignored
    run_instr(32'h69080002, 5'b01010, K_IMM, 8'h38, -1); // Stop held through T5
    halt_wait(3);
    do_reset(1);
    run_instr(32'hD0000000, 5'b00000, K_HLT, 8'h00, -1); // halt
    halt_wait(2);
    do_reset(1);
    run_instr(32'hC8000000, 5'b00000, K_NOP, 8'h04, -1); // Stop at nop T2
    halt_wait(1);
    do_reset(1);
    run_instr(32'h00800055, 5'b00011, K_LD,  8'h00, 6);  // Clear pulsed in ld T6
    do_reset(1);
    run_instr(32'h1A920000, 5'b00011, K_R,   8'h00, -1);
    tick(); push(ST_T0, exp_sb(K_R, 0), 1'b1);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge Clock);
    finish_req = 1'b1;
  end

endmodule
